regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
Debug read-side companion to the CPU register file. On a start pulse it walks register numbers 0..NUM_REGS-1 through one register-file read port. It streams each 16-bit value as a framed byte sequence over a valid/ready byte interface, which typically feeds the UART TX. The frame is a header byte, then two bytes per register (high byte first), then an XOR checksum byte.

Parameters:
NUM_REGS, 16, number of registers dumped (2..16); rd_addr walks 0..NUM_REGS-1
HEADER, 8'hA5, frame start byte

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin a dump; ignored while busy
rd_addr  output  4  register number driven to register-file read port (outRegN)
rd_data  input  16  combinational read data from register file for rd_addr
byte_out  output  8  stream byte
byte_valid  output  1  byte_out valid
byte_ready  input  1  sink accepts byte when byte_valid && byte_ready
busy  output  1  high from cycle after start until frame complete
done  output  1  one-cycle pulse after checksum byte accepted

Behaviour:
- Reset (async, any state): state=IDLE, rd_addr=0, byte_out=0, byte_valid=0, busy=0, done=0, idx=0, csum=0, data_q=0; partial frame abandoned, no done.
- All outputs registered. rd_data sampled only at the clock edge leaving LOAD.
- States: IDLE, HDR, LOAD, HI, LO, SUM.
- IDLE: on start=1 -> HDR; byte_out<=HEADER, byte_valid<=1, busy<=1, csum<=0, idx<=0.
- HDR: hold until accept. On accept -> LOAD; byte_valid<=0, rd_addr<=idx.
- LOAD (exactly 1 cycle, byte_valid=0): data_q<=rd_data; byte_out<=rd_data[15:8], byte_valid<=1 -> HI.
- HI: on accept: csum^=byte_out; byte_out<=data_q[7:0] -> LO (byte_valid stays 1).
- LO: on accept: csum^=byte_out.
  - If idx==NUM_REGS-1: byte_out<=csum^data_q[7:0], -> SUM.
  - Else: idx<=idx+1, rd_addr<=idx+1, byte_valid<=0, -> LOAD.
- SUM: on accept: byte_valid<=0, busy<=0, done<=1 (one cycle) -> IDLE.
- Handshake rules:
  - byte_out and byte_valid stay stable while byte_valid && !byte_ready.
  - byte_valid never drops without an accept.
  - byte_ready is ignored while byte_valid=0.
- Checksum: XOR of all 2*NUM_REGS data bytes; the header is excluded.
- Frame length: 2*NUM_REGS+2 bytes (34 for the default).
- Latency with byte_ready=1 constantly:
  - HDR valid in the cycle after start.
  - 3 cycles per register (LOAD, HI, LO), SUM for 1 cycle.
  - done asserted 3*NUM_REGS+2 cycles after start is sampled (50 for the default).
- Coherency: each register is sampled at its own LOAD cycle. There is no whole-file snapshot; a write to reg k before its LOAD edge is reflected in the dump.
- start while busy: ignored, with no queuing. start in the same cycle done is asserted (state IDLE) begins a new frame.
- done and busy are never high together.

Test Plan:
1. Regs r0=0x1234, r1=0x00FF, others 0; start, byte_ready=1 -> bytes A5,12,34,00,FF,00 x28,D9; 34 accepts; done pulses once, 50 cycles after start.
2. Same regs, byte_ready toggled pseudo-randomly (~40% duty) -> identical byte sequence; byte_out stable whenever valid && !ready; no byte duplicated or dropped.
3. start pulsed again at mid-frame (byte 10) -> frame unaffected, still 34 bytes, single done; idle start afterwards -> second full frame.
4. Assert rst while in HI of r5 -> all outputs 0 immediately (async); after release and start -> fresh frame beginning A5 with correct checksum.
5. Write r3=0xBEEF during r1 dump (before r3's LOAD) -> r3 bytes BE,EF appear; write r0 after its LOAD -> old r0 value appears.
6. NUM_REGS=2, r0=0xAAAA, r1=0x5555 -> A5,AA,AA,55,55,00; rd_addr only takes values 0 and 1.

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Debug companion to the CPU register file: walks registers 0..NUM_REGS-1 through one read
// port and streams them as a framed byte sequence (header, hi/lo per register, XOR checksum).
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// HDR   | header byte offered, waiting for accept
// LOAD  | rd_addr settled; rd_data captured at the edge leaving this state
// HI    | high byte of current register offered
// LO    | low byte of current register offered
// SUM   | checksum byte offered; accept ends the frame with a done pulse
module regfile_dump_reader #(
    parameter int          NUM_REGS = 16,
    parameter logic [7:0]  HEADER   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        LOAD,
        HI,
        LO,
        SUM
    } state_t;

    localparam logic [3:0] LAST = 4'(NUM_REGS - 1);

    state_t      state, state_nx;
    logic [3:0]  idx, idx_nx;
    logic [3:0]  rd_addr_nx;
    logic [7:0]  csum, csum_nx;
    logic [7:0]  byte_out_nx;
    logic [15:0] data_q, data_q_nx;
    logic        byte_valid_nx;
    logic        busy_nx;
    logic        done_nx;
    logic        accept;

    assign accept = byte_valid && byte_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            rd_addr    <= '0;
            csum       <= '0;
            byte_out   <= '0;
            data_q     <= '0;
            byte_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            rd_addr    <= rd_addr_nx;
            csum       <= csum_nx;
            byte_out   <= byte_out_nx;
            data_q     <= data_q_nx;
            byte_valid <= byte_valid_nx;
            busy       <= busy_nx;
            done       <= done_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        idx_nx        = idx;
        rd_addr_nx    = rd_addr;
        csum_nx       = csum;
        byte_out_nx   = byte_out;
        data_q_nx     = data_q;
        byte_valid_nx = byte_valid;
        busy_nx       = busy;
        done_nx       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nx      = HDR;
                    byte_out_nx   = HEADER;
                    byte_valid_nx = 1'b1;
                    busy_nx       = 1'b1;
                    csum_nx       = '0;
                    idx_nx        = '0;
                end
            end
            HDR: begin
                if (accept) begin
                    state_nx      = LOAD;
                    byte_valid_nx = 1'b0;
                    rd_addr_nx    = idx;
                end
            end
            LOAD: begin
                state_nx      = HI;
                data_q_nx     = rd_data;
                byte_out_nx   = rd_data[15:8];
                byte_valid_nx = 1'b1;
            end
            HI: begin
                if (accept) begin
                    state_nx    = LO;
                    csum_nx     = csum ^ byte_out;
                    byte_out_nx = data_q[7:0];
                end
            end
            LO: begin
                if (accept) begin
                    csum_nx = csum ^ byte_out;
                    if (idx == LAST) begin
                        // byte_out holds data_q[7:0] here, so this folds the last byte in
                        state_nx    = SUM;
                        byte_out_nx = csum ^ data_q[7:0];
                    end else begin
                        state_nx      = LOAD;
                        idx_nx        = idx + 4'd1;
                        rd_addr_nx    = idx + 4'd1;
                        byte_valid_nx = 1'b0;
                    end
                end
            end
            SUM: begin
                if (accept) begin
                    state_nx      = IDLE;
                    byte_valid_nx = 1'b0;
                    busy_nx       = 1'b0;
                    done_nx       = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: frame content, handshake stalls, restart/busy,
// async reset mid-frame, per-register read coherency and a two-register instance.
module tb_regfile_dump_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;
    logic        busy;
    logic        done;

    logic        start2;
    logic [3:0]  rd_addr2;
    logic [15:0] rd_data2;
    logic [7:0]  byte_out2;
    logic        byte_valid2;
    logic        byte_ready2;
    logic        busy2;
    logic        done2;

    logic [15:0] regs  [16];
    logic [15:0] regs2 [2];
    logic [15:0] ev    [16];

    always #5 clk = ~clk;

    assign rd_data  = regs[rd_addr];
    assign rd_data2 = regs2[rd_addr2[0]];

    regfile_dump_reader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .busy       (busy),
        .done       (done)
    );

    regfile_dump_reader #(.NUM_REGS(2)) dut2 (
        .clk        (clk),
        .rst        (rst),
        .start      (start2),
        .rd_addr    (rd_addr2),
        .rd_data    (rd_data2),
        .byte_out   (byte_out2),
        .byte_valid (byte_valid2),
        .byte_ready (byte_ready2),
        .busy       (busy2),
        .done       (done2)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got   [$];
    logic [7:0] exp_q [$];
    int         ncall;
    int         done_cnt;
    int         done_call;
    int         first_valid_call;
    logic       prev_stall;
    logic [7:0] prev_byte;
    int         start_at_byte;
    bit         start_fired;
    int         wr_trig;
    bit         wr_fired;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic clear_regs();
        for (int i = 0; i < 16; i++) begin
            regs[i] = '0;
            ev[i]   = '0;
        end
    endtask

    task automatic build_exp();
        logic [7:0] c;
        c = 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(ev[i][15:8]);
            exp_q.push_back(ev[i][7:0]);
            c = c ^ ev[i][15:8] ^ ev[i][7:0];
        end
        exp_q.push_back(c);
    endtask

    // One clock: drive ready, observe at negedge, advance to just after the next posedge.
    task automatic cycle(input logic rdy);
        byte_ready = rdy;
        if (start_at_byte >= 0 && !start_fired && got.size() == start_at_byte) begin
            start       = 1'b1;
            start_fired = 1'b1;
        end
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_byte_stable", {24'h0, byte_out}, {24'h0, prev_byte});
            chk("stall_valid_held", {31'h0, byte_valid}, 32'h1);
        end
        chk("busy_done_exclusive", {31'h0, busy && done}, 32'h0);
        if (done) begin
            done_cnt++;
            done_call = ncall;
        end
        if (byte_valid && first_valid_call < 0) first_valid_call = ncall;
        if (byte_valid && rdy) got.push_back(byte_out);
        prev_stall = byte_valid && !rdy;
        prev_byte  = byte_out;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (wr_trig >= 0 && !wr_fired && rd_addr == wr_trig[3:0]) begin
            regs[3]  = 16'hBEEF;
            regs[0]  = 16'h7777;
            wr_fired = 1'b1;
        end
        ncall++;
    endtask

    task automatic run_frame(input int mode, input int budget);
        int extra;
        logic rdy;
        ncall            = 0;
        done_cnt         = 0;
        done_call        = -1;
        first_valid_call = -1;
        extra            = 0;
        got.delete();
        for (int i = 0; i < budget; i++) begin
            rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 4);
            cycle(rdy);
            if (done_cnt > 0) extra++;
            if (extra > 3) break;
        end
        chk("frame_done_count", done_cnt, 32'd1);
    endtask

    task automatic cmp_frame(input string tag);
        chk({tag, "_len"}, got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) chk($sformatf("%s[%0d]", tag, i), {24'h0, got[i]}, {24'h0, exp_q[i]});
        end
    endtask

    initial begin
        int d2cnt;
        int d2call;
        rst           = 1'b1;
        start         = 1'b0;
        start2        = 1'b0;
        byte_ready    = 1'b0;
        byte_ready2   = 1'b0;
        start_at_byte = -1;
        start_fired   = 1'b0;
        wr_trig       = -1;
        wr_fired      = 1'b0;
        prev_stall    = 1'b0;
        prev_byte     = '0;
        regs2[0]      = '0;
        regs2[1]      = '0;
        clear_regs();
        #2;
        chk("rst_byte_out", {24'h0, byte_out}, 32'h0);
        chk("rst_byte_valid", {31'h0, byte_valid}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_rd_addr", {28'h0, rd_addr}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: basic frame, ready always high
        clear_regs();
        regs[0] = 16'h1234; regs[1] = 16'h00FF;
        ev[0]   = 16'h1234; ev[1]   = 16'h00FF;
        build_exp();
        start = 1'b1;
        run_frame(0, 200);
        cmp_frame("t1");
        chk("t1_hdr_valid_call", first_valid_call, 32'd1);
        chk("t1_done_latency", done_call, 32'd51);
        if (got.size() == 34) begin
            chk("t1_byte1", {24'h0, got[1]}, 32'h12);
            chk("t1_byte4", {24'h0, got[4]}, 32'hFF);
            chk("t1_csum", {24'h0, got[33]}, 32'hD9);
        end

        // 2: same frame with a stalling sink
        start = 1'b1;
        run_frame(1, 2000);
        cmp_frame("t2");

        // 3: start mid-frame is ignored, then an idle start gives a second frame
        start_at_byte = 10;
        start_fired   = 1'b0;
        start         = 1'b1;
        run_frame(0, 200);
        cmp_frame("t3a");
        chk("t3_mid_start_issued", {31'h0, start_fired}, 32'h1);
        start_at_byte = -1;
        start = 1'b1;
        run_frame(0, 200);
        cmp_frame("t3b");

        // 4: async reset while r5's high byte is on offer
        regs[5] = 16'hC3C3;
        ev[5]   = 16'hC3C3;
        build_exp();
        got.delete();
        ncall = 0;
        start = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (got.size() == 11) break;
            cycle(1'b1);
        end
        cycle(1'b0);
        cycle(1'b0);
        chk("t4_in_hi_valid", {31'h0, byte_valid}, 32'h1);
        chk("t4_in_hi_addr", {28'h0, rd_addr}, 32'h5);
        chk("t4_in_hi_byte", {24'h0, byte_out}, 32'hC3);
        rst = 1'b1;
        #1;
        chk("t4_rst_byte_out", {24'h0, byte_out}, 32'h0);
        chk("t4_rst_valid", {31'h0, byte_valid}, 32'h0);
        chk("t4_rst_busy", {31'h0, busy}, 32'h0);
        chk("t4_rst_rd_addr", {28'h0, rd_addr}, 32'h0);
        @(posedge clk);
        #1;
        chk("t4_rst_done", {31'h0, done}, 32'h0);
        rst        = 1'b0;
        prev_stall = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        run_frame(0, 200);
        cmp_frame("t4");

        // 5: r3 written before its LOAD shows up; r0 written after its LOAD does not
        clear_regs();
        regs[0] = 16'h1234; regs[1] = 16'h00FF;
        ev[0]   = 16'h1234; ev[1]   = 16'h00FF; ev[3] = 16'hBEEF;
        build_exp();
        wr_trig  = 1;
        wr_fired = 1'b0;
        start    = 1'b1;
        run_frame(0, 200);
        cmp_frame("t5");
        chk("t5_write_issued", {31'h0, wr_fired}, 32'h1);
        if (got.size() == 34) begin
            chk("t5_r0_hi_old", {24'h0, got[1]}, 32'h12);
            chk("t5_r3_hi", {24'h0, got[7]}, 32'hBE);
            chk("t5_r3_lo", {24'h0, got[8]}, 32'hEF);
            chk("t5_csum", {24'h0, got[33]}, 32'h88);
        end
        wr_trig = -1;

        // 6: two-register instance
        regs2[0] = 16'hAAAA;
        regs2[1] = 16'h5555;
        exp_q.delete();
        exp_q.push_back(8'hA5); exp_q.push_back(8'hAA); exp_q.push_back(8'hAA);
        exp_q.push_back(8'h55); exp_q.push_back(8'h55); exp_q.push_back(8'h00);
        got.delete();
        d2cnt  = 0;
        d2call = -1;
        start2 = 1'b1;
        for (int i = 0; i < 60; i++) begin
            byte_ready2 = 1'b1;
            @(negedge clk);
            chk("t6_addr_range", {31'h0, rd_addr2 < 4'd2}, 32'h1);
            if (byte_valid2) got.push_back(byte_out2);
            if (done2) begin
                d2cnt++;
                d2call = i;
            end
            @(posedge clk);
            #1;
            start2 = 1'b0;
            if (d2cnt > 0 && i > d2call + 2) break;
        end
        cmp_frame("t6");
        chk("t6_done_count", d2cnt, 32'd1);
        chk("t6_done_latency", d2call, 32'd9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
